irq_controller: RTL

IRQ_CONTROLLER -- requirements
Module: irq_controller

---
 rtl/irq_controller.sv | 111 +++++++++++
 1 files changed

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - prioritised edge-triggered interrupt controller with register window
module irq_controller #(
  parameter int          N_SRC     = 4,
  parameter logic [15:0] VEC_RESET = 16'h0010
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_SRC-1:0] src,
  input  logic             ack,
  input  logic             eoi,
  input  logic             cfg_write,
  input  logic [1:0]       cfg_addr,
  input  logic [15:0]      cfg_wdata,
  output logic [15:0]      cfg_rdata,
  output logic             irq,
  output logic [15:0]      vector
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t           state;
  logic [N_SRC-1:0] src_prev;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] mask;
  logic [15:0]      vec_base;
  logic [1:0]       active_id;

  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] active_onehot;
  logic [N_SRC-1:0] w1c_clear;
  logic [N_SRC-1:0] ack_clear;
  logic             sel_any;
  logic [1:0]       sel_id;
  logic             active_ok;

  assign rise          = src & ~src_prev;
  assign eligible      = pending & mask;
  assign active_onehot = N_SRC'(1) << active_id;
  assign active_ok     = |(eligible & active_onehot);
  assign w1c_clear     = (cfg_write && cfg_addr == 2'd1) ? cfg_wdata[N_SRC-1:0] : '0;
  assign ack_clear     = (state == REQ && ack) ? active_onehot : '0;
  assign sel_any       = |eligible;

  // Lowest enabled pending index wins arbitration.
  always_comb begin
    sel_id = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) sel_id = 2'(i);
    end
  end

  // Register read mux; unused bits read zero.
  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      2'd0: cfg_rdata[N_SRC-1:0] = mask;
      2'd1: cfg_rdata[N_SRC-1:0] = pending;
      2'd2: cfg_rdata = {(state == SERVICE), irq, 12'd0, active_id};
      default: cfg_rdata = vec_base;
    endcase
  end

  // Edge capture, config registers and the IDLE/REQ/SERVICE sequencer.
  always_ff @(posedge clock) begin
    src_prev <= src;
    if (reset) begin
      state     <= IDLE;
      irq       <= 1'b0;
      pending   <= '0;
      mask      <= '0;
      active_id <= '0;
      vec_base  <= VEC_RESET;
      vector    <= VEC_RESET;
    end else begin
      // A new edge beats any clear of the same bit.
      pending <= (pending & ~(w1c_clear | ack_clear)) | rise;
      if (cfg_write && cfg_addr == 2'd0) mask <= cfg_wdata[N_SRC-1:0];
      if (cfg_write && cfg_addr == 2'd3) vec_base <= cfg_wdata;

      case (state)
        IDLE: begin
          if (sel_any) begin
            active_id <= sel_id;
            vector    <= vec_base + {12'd0, sel_id, 2'b00};
            state     <= REQ;
            irq       <= 1'b1;
          end
        end
        REQ: begin
          if (ack) begin
            state <= SERVICE;
            irq   <= 1'b0;
          end else if (!active_ok) begin
            // Source withdrawn by mask or software clear: no handler is owed.
            state <= IDLE;
            irq   <= 1'b0;
          end
        end
        SERVICE: begin
          if (eoi) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          irq   <= 1'b0;
        end
      endcase
    end
  end

endmodule
